// File: rtl/tex_stream_sequencer_if.sv
// Memory and line_mapper side of tex_stream_sequencer: line index out, start pointers in,
// word address out, registered 16-bit read data in.
interface tex_stream_sequencer_if;
    logic [5:0]  ptr_line;
    logic [7:0]  lhs_ptr;
    logic [7:0]  rhs_ptr;
    logic [7:0]  mem_addr;
    logic [15:0] mem_dout;

    modport master (
        output ptr_line,
        output mem_addr,
        input  lhs_ptr,
        input  rhs_ptr,
        input  mem_dout
    );

    modport slave (
        input  ptr_line,
        input  mem_addr,
        output lhs_ptr,
        output rhs_ptr,
        output mem_dout
    );
endinterface

// File: rtl/tex_stream_sequencer.sv
// Streams the LHS/RHS packed-ASCII strings of one transform line, one character pair per paced tick.
// Optional feature macro: TEX_BEACON_EN (adds beacon_i, streams a fixed call-sign string instead of memory).
//
// state   | meaning
// IDLE    | waiting for start
// PTR     | line_mapper pointers valid, capture start addresses
// FETCH_L | present LHS word address
// FETCH_R | present RHS word address, capture LHS word
// CAP_R   | capture RHS word, load tick divider
// WAIT_HI | pacing wait before the high-byte slot
// EMIT_HI | emit high-byte character pair
// WAIT_LO | pacing wait before the low-byte slot
// EMIT_LO | emit low-byte character pair, advance word
// DONE    | stream finished, outputs hold last pair
module tex_stream_sequencer #(
    parameter int MAX_WORDS = 32,
    parameter int DIV_W     = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_i,
    input  logic [5:0]             line_i,
    input  logic [1:0]             div_sel_i,
`ifdef TEX_BEACON_EN
    input  logic                   beacon_i,
`endif
    tex_stream_sequencer_if.master mem_if,
    output logic [7:0]             lhs_o,
    output logic [7:0]             rhs_o,
    output logic                   char_valid_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overflow_o
);
    localparam int WCNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [3:0] {
        IDLE, PTR, FETCH_L, FETCH_R, CAP_R, WAIT_HI, EMIT_HI, WAIT_LO, EMIT_LO, DONE
    } state_e;

    state_e            state_q, state_d;
    logic [5:0]        ptr_line_q, ptr_line_d;
    logic [7:0]        l_addr_q, l_addr_d, r_addr_q, r_addr_d;
    logic [7:0]        mem_addr_q, mem_addr_d;
    logic [15:0]       l_word_q, l_word_d, r_word_q, r_word_d;
    logic [7:0]        lhs_q, lhs_d, rhs_q, rhs_d;
    logic [DIV_W-1:0]  div_q, div_d, div_load;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              term_l_q, term_l_d, term_r_q, term_r_d;
    logic              overflow_q, overflow_d;
    logic              beacon_mode;
    logic [15:0]       beacon_word;
    logic              emit_hi;
    logic [7:0]        l_c, r_c;

`ifdef TEX_BEACON_EN
    logic beacon_q, beacon_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) beacon_q <= 1'b0;
        else        beacon_q <= beacon_d;
    end

    always_comb begin
        beacon_d = beacon_q;
        if ((state_q == IDLE || state_q == DONE) && start_i) beacon_d = beacon_i;
    end

    // "CQ DE KC1GPW", high byte first; the word after the last reads as NUL to end the stream
    always_comb begin
        case (int'(wcnt_q))
            0:       beacon_word = 16'h4351;
            1:       beacon_word = 16'h2044;
            2:       beacon_word = 16'h4520;
            3:       beacon_word = 16'h4B43;
            4:       beacon_word = 16'h3147;
            5:       beacon_word = 16'h5057;
            default: beacon_word = 16'h0000;
        endcase
    end

    assign beacon_mode = beacon_q;
`else
    assign beacon_mode = 1'b0;
    assign beacon_word = 16'h0000;
`endif

    // divider is a down-counter loaded with period-1 on WAIT entry
    always_comb begin
        case (div_sel_i)
            2'd0:    div_load = DIV_W'(0);
            2'd1:    div_load = DIV_W'(15);
            2'd2:    div_load = DIV_W'(255);
            default: div_load = DIV_W'(65535);
        endcase
    end

    assign emit_hi = (state_q == EMIT_HI);
    assign l_c = term_l_q ? 8'h00 : (emit_hi ? l_word_q[15:8] : l_word_q[7:0]);
    assign r_c = term_r_q ? 8'h00 : (emit_hi ? r_word_q[15:8] : r_word_q[7:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_line_q <= '0;
            l_addr_q   <= '0;
            r_addr_q   <= '0;
            mem_addr_q <= '0;
            l_word_q   <= '0;
            r_word_q   <= '0;
            lhs_q      <= '0;
            rhs_q      <= '0;
            div_q      <= '0;
            wcnt_q     <= '0;
            term_l_q   <= 1'b0;
            term_r_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_line_q <= ptr_line_d;
            l_addr_q   <= l_addr_d;
            r_addr_q   <= r_addr_d;
            mem_addr_q <= mem_addr_d;
            l_word_q   <= l_word_d;
            r_word_q   <= r_word_d;
            lhs_q      <= lhs_d;
            rhs_q      <= rhs_d;
            div_q      <= div_d;
            wcnt_q     <= wcnt_d;
            term_l_q   <= term_l_d;
            term_r_q   <= term_r_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_line_d   = ptr_line_q;
        l_addr_d     = l_addr_q;
        r_addr_d     = r_addr_q;
        mem_addr_d   = mem_addr_q;
        l_word_d     = l_word_q;
        r_word_d     = r_word_q;
        lhs_d        = lhs_q;
        rhs_d        = rhs_q;
        div_d        = div_q;
        wcnt_d       = wcnt_q;
        term_l_d     = term_l_q;
        term_r_d     = term_r_q;
        overflow_d   = overflow_q;
        char_valid_o = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    ptr_line_d = line_i;
                    overflow_d = 1'b0;
                    term_l_d   = 1'b0;
                    term_r_d   = 1'b0;
                    wcnt_d     = '0;
                    state_d    = PTR;
                end
            end
            PTR: begin
                l_addr_d = mem_if.lhs_ptr;
                r_addr_d = mem_if.rhs_ptr;
                state_d  = FETCH_L;
            end
            FETCH_L: begin
                if (!beacon_mode) mem_addr_d = l_addr_q;
                state_d = FETCH_R;
            end
            FETCH_R: begin
                if (!beacon_mode) mem_addr_d = r_addr_q;
                l_word_d = beacon_mode ? beacon_word : mem_if.mem_dout;
                state_d  = CAP_R;
            end
            CAP_R: begin
                r_word_d = beacon_mode ? 16'h0000 : mem_if.mem_dout;
                div_d    = div_load;
                state_d  = WAIT_HI;
            end
            WAIT_HI, WAIT_LO: begin
                if (div_q == '0) state_d = (state_q == WAIT_HI) ? EMIT_HI : EMIT_LO;
                else             div_d   = div_q - DIV_W'(1);
            end
            EMIT_HI, EMIT_LO: begin
                if (l_c == 8'h00 && r_c == 8'h00) begin
                    state_d = DONE;
                end else begin
                    lhs_d        = l_c;
                    rhs_d        = r_c;
                    char_valid_o = 1'b1;
                    term_l_d     = term_l_q | (l_c == 8'h00);
                    term_r_d     = term_r_q | (r_c == 8'h00);
                    if (emit_hi) begin
                        div_d   = div_load;
                        state_d = WAIT_LO;
                    end else begin
                        wcnt_d = wcnt_q + WCNT_W'(1);
                        if (!term_l_d) l_addr_d = l_addr_q + 8'd1;
                        if (!term_r_d) r_addr_d = r_addr_q + 8'd1;
                        if (wcnt_d == WCNT_W'(MAX_WORDS)) begin
                            overflow_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            state_d = FETCH_L;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign mem_if.ptr_line = ptr_line_q;
    assign mem_if.mem_addr = mem_addr_d;
    assign lhs_o           = lhs_d;
    assign rhs_o           = rhs_d;
    assign busy_o          = (state_q != IDLE) && (state_q != DONE);
    assign done_o          = (state_q == DONE);
    assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_tex_stream_sequencer.sv
// Bench for tex_stream_sequencer: table of line scenarios, hand-written corner sequences and
// randomized strings, all checked against a string/timing model computed from the pacing rules.
module tb_tex_stream_sequencer;
    localparam int MAXW = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [5:0] line;
    logic [1:0] div_sel;
`ifdef TEX_BEACON_EN
    logic       beacon;
`endif
    logic [7:0] lhs, rhs;
    logic       char_valid, busy, done, overflow;

    tex_stream_sequencer_if ifc();

    tex_stream_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .line_i       (line),
        .div_sel_i    (div_sel),
`ifdef TEX_BEACON_EN
        .beacon_i     (beacon),
`endif
        .mem_if       (ifc),
        .lhs_o        (lhs),
        .rhs_o        (rhs),
        .char_valid_o (char_valid),
        .busy_o       (busy),
        .done_o       (done),
        .overflow_o   (overflow)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [256];
    logic [7:0]  lmap_l [64];
    logic [7:0]  lmap_r [64];
    logic [15:0] mem_q;

    always @(posedge clk) mem_q <= mem[ifc.mem_addr];
    assign ifc.mem_dout = mem_q;
    assign ifc.lhs_ptr  = lmap_l[ifc.ptr_line];
    assign ifc.rhs_ptr  = lmap_r[ifc.ptr_line];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int         t;
        logic [7:0] l;
        logic [7:0] r;
    } pulse_t;

    typedef struct {
        logic [5:0] ln;
        logic [1:0] ds;
        int         npulse;
        logic       ovf;
        logic [7:0] last_l;
        logic [7:0] last_r;
    } vec_t;

    pulse_t got[$];
    pulse_t exp_q[$];
    int     s, done_t, exp_done_t;
    logic   exp_ovf;
    logic   armed;
    int     checks, passes;
    vec_t   tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        if (armed) begin
            pulse_t p;
            if (char_valid) begin
                p.t = cyc - s;
                p.l = lhs;
                p.r = rhs;
                got.push_back(p);
            end
            if (done && done_t < 0) done_t = cyc - s;
        end
        #1;
    endtask

    function automatic int period(input logic [1:0] ds);
        case (ds)
            2'd0:    return 1;
            2'd1:    return 16;
            2'd2:    return 256;
            default: return 65536;
        endcase
    endfunction

    function automatic logic [7:0] char_at(input logic [7:0] ptr, input int k);
        logic [15:0] w;
        w = mem[ptr + 8'(k / 2)];
        return (k % 2 == 0) ? w[15:8] : w[7:0];
    endfunction

    // Expected pulses: slot k pairs the k-th chars (0 past each string's end); stop when both ended
    // or after 2*MAXW slots. Timing relative to the start cycle: first emit 5+P, low emit +1+P,
    // next high emit +4+P.
    task automatic build_model(input logic [7:0] lp, input logic [7:0] rp, input int p0, input int p1);
        int     len_l, len_r, n, t, p;
        pulse_t pe;
        len_l = 2 * MAXW;
        len_r = 2 * MAXW;
        for (int k = 2 * MAXW - 1; k >= 0; k--) begin
            if (char_at(lp, k) == 8'h00) len_l = k;
            if (char_at(rp, k) == 8'h00) len_r = k;
        end
        n       = (len_l > len_r) ? len_l : len_r;
        exp_ovf = (n == 2 * MAXW);
        exp_q.delete();
        t = 0;
        for (int k = 0; k <= n && k < 2 * MAXW; k++) begin
            p = (k == 0) ? p0 : p1;
            if (k == 0)          t = 5 + p;
            else if (k % 2 == 1) t = t + 1 + p;
            else                 t = t + 4 + p;
            if (k < n) begin
                pe.t = t;
                pe.l = (k < len_l) ? char_at(lp, k) : 8'h00;
                pe.r = (k < len_r) ? char_at(rp, k) : 8'h00;
                exp_q.push_back(pe);
            end
            exp_done_t = t + 1;
        end
    endtask

    task automatic kick(input logic [5:0] ln, input logic [1:0] ds);
        got.delete();
        done_t  = -1;
        armed   = 1'b0;
        start   = 1'b1;
        line    = ln;
        div_sel = ds;
        s       = cyc;
        step();
        start = 1'b0;
        armed = 1'b1;
        chk("start_accept", {busy, done, overflow, ifc.ptr_line}, {1'b1, 1'b0, 1'b0, ln});
    endtask

    task automatic wait_done(input int budget);
        while (!done && (cyc - s) < budget) step();
        chk("done_reached", done, 1'b1);
    endtask

    task automatic run_and_check(input logic [7:0] lp, input logic [7:0] rp, input int p0, input int p1);
        int m;
        build_model(lp, rp, p0, p1);
        wait_done(exp_done_t + 50);
        chk("pulse_count", got.size(), exp_q.size());
        m = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < m; i++) chk($sformatf("pulse%0d_t_l_r", i), got[i], exp_q[i]);
        chk("overflow", overflow, exp_ovf);
        chk("done_cycle", done_t, exp_done_t);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] lp, rp, ma;
        logic [5:0] ln;
        logic [1:0] ds;
        int         nl, nr, n0;
        string      bstr;

        checks = 0; passes = 0; armed = 1'b0; s = 0; done_t = -1;
        rst_n = 1'b0; start = 1'b0; line = '0; div_sel = '0;
`ifdef TEX_BEACON_EN
        beacon = 1'b0;
`endif
        for (int a = 0; a < 256; a++) mem[a] = 16'h0000;
        for (int i = 0; i < 64; i++) begin lmap_l[i] = 8'h70; lmap_r[i] = 8'h70; end
        lmap_l[3] = 8'h10; lmap_r[3] = 8'h20;
        mem[8'h10] = 16'h5C66; mem[8'h11] = 16'h2800;
        mem[8'h20] = 16'h3173; mem[8'h21] = 16'h0000;
        lmap_l[5] = 8'h30; lmap_r[5] = 8'h40;
        mem[8'h30] = 16'h4142; mem[8'h31] = 16'h0043;
        mem[8'h40] = 16'h6162; mem[8'h41] = 16'h0063;
        lmap_l[7] = 8'hF0; lmap_r[7] = 8'hC0;
        for (int a = 0; a < 16; a++) begin
            mem[8'hF0 + a] = {8'h41 + 8'(a), 8'h61 + 8'(a)};
            mem[8'h00 + a] = {8'h41 + 8'(a), 8'h61 + 8'(a)};
        end
        for (int a = 0; a < 32; a++) mem[8'hC0 + a] = {8'h30 + 8'(a % 16), 8'h40 + 8'(a % 16)};
        lmap_l[9] = 8'h50; lmap_r[9] = 8'h60;
        mem[8'h50] = 16'h4100;
        mem[8'h60] = 16'h7879; mem[8'h61] = 16'h7A00;

        tbl[0] = '{6'd3,  2'd0, 3,  1'b0, 8'h28, 8'h00};
        tbl[1] = '{6'd3,  2'd1, 3,  1'b0, 8'h28, 8'h00};
        tbl[2] = '{6'd5,  2'd0, 2,  1'b0, 8'h42, 8'h62};
        tbl[3] = '{6'd7,  2'd0, 64, 1'b1, 8'h70, 8'h4F};
        tbl[4] = '{6'd9,  2'd1, 3,  1'b0, 8'h00, 8'h7A};
        tbl[5] = '{6'd11, 2'd0, 0,  1'b0, 8'h00, 8'h7A};

        repeat (3) step();
        chk("reset_outputs", {lhs, rhs, char_valid, busy, done, overflow, ifc.mem_addr, ifc.ptr_line}, '0);
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) begin
            kick(tbl[i].ln, tbl[i].ds);
            run_and_check(lmap_l[tbl[i].ln], lmap_r[tbl[i].ln], period(tbl[i].ds), period(tbl[i].ds));
            chk($sformatf("tbl%0d_npulse", i), got.size(), tbl[i].npulse);
            chk($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
            chk($sformatf("tbl%0d_hold", i), {lhs, rhs, busy}, {tbl[i].last_l, tbl[i].last_r, 1'b0});
            repeat (3) step();
        end

        // divider period is sampled on WAIT entry: 256 for the first wait, 1 afterwards
        kick(6'd3, 2'd2);
        repeat (10) step();
        div_sel = 2'd0;
        run_and_check(8'h10, 8'h20, 256, 1);
        repeat (3) step();

        // start while busy must not re-latch the line
        kick(6'd5, 2'd1);
        repeat (8) step();
        start = 1'b1; line = 6'd3;
        step();
        start = 1'b0;
        chk("ignored_start", {busy, ifc.ptr_line}, {1'b1, 6'd5});
        run_and_check(8'h30, 8'h40, 16, 16);
        repeat (3) step();

        // asynchronous reset in WAIT_LO
        kick(6'd3, 2'd1);
        n0 = 0;
        while (got.size() == 0 && n0 < 200) begin step(); n0++; end
        chk("first_pulse_before_reset", got.size(), 1);
        repeat (3) step();
        #2 rst_n = 1'b0;
        #1 chk("reset_midstream", {lhs, rhs, char_valid, busy, done, overflow, ifc.mem_addr, ifc.ptr_line}, '0);
        step();
        got.delete();
        rst_n = 1'b1;
        repeat (60) step();
        chk("no_pulse_after_reset", {got.size(), busy, done}, '0);

        for (int it = 0; it < 20; it++) begin
            ln = 6'(32 + it);
            lp = 8'h80 + 8'($urandom_range(0, 8));
            rp = 8'hA0 + 8'($urandom_range(0, 8));
            lmap_l[ln] = lp; lmap_r[ln] = rp;
            for (int w = 0; w < 16; w++) begin
                mem[lp + 8'(w)] = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
                mem[rp + 8'(w)] = {8'($urandom_range(1, 255)), 8'($urandom_range(1, 255))};
            end
            nl = $urandom_range(0, 31);
            nr = (it % 4 == 0) ? nl : $urandom_range(0, 31);
            if (nl % 2 == 0) mem[lp + 8'(nl / 2)][15:8] = 8'h00; else mem[lp + 8'(nl / 2)][7:0] = 8'h00;
            if (nr % 2 == 0) mem[rp + 8'(nr / 2)][15:8] = 8'h00; else mem[rp + 8'(nr / 2)][7:0] = 8'h00;
            ds = 2'($urandom_range(0, 1));
            kick(ln, ds);
            run_and_check(lp, rp, period(ds), period(ds));
            repeat (2) step();
        end

`ifdef TEX_BEACON_EN
        bstr = "CQ DE KC1GPW";
        ma = ifc.mem_addr;
        beacon = 1'b1;
        kick(6'd3, 2'd0);
        beacon = 1'b0;
        wait_done(200);
        chk("beacon_count", got.size(), 12);
        for (int i = 0; i < 12 && i < got.size(); i++)
            chk($sformatf("beacon%0d", i), {got[i].l, got[i].r}, {bstr[i], 8'h00});
        chk("beacon_mem_addr", ifc.mem_addr, ma);
`else
        bstr = "";
        ma = 8'h00;
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
